// File: rtl/branch_sequencer_pkg.sv
// Shared control definitions for the branch execute sequencer and the
// branch-condition evaluator: state encoding, branch opcode, condition codes
// and the per-state datapath strobe decode.
package branch_sequencer_pkg;

  // Execute-phase state encoding
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_T3   = 3'd1,
    ST_T4   = 3'd2,
    ST_T5   = 3'd3,
    ST_T6   = 3'd4
  } state_e;

  // Instruction format fields
  localparam int unsigned IR_W       = 32;
  localparam int unsigned OPCODE_W   = 5;
  localparam int unsigned OPCODE_LSB = 27;

  localparam logic [OPCODE_W-1:0] BR_OPCODE = 5'b10010;

  // Condition codes carried in IR[20:19], decoded by the evaluator
  localparam logic [1:0] CC_ZERO    = 2'b00;
  localparam logic [1:0] CC_NONZERO = 2'b01;
  localparam logic [1:0] CC_POS     = 2'b10;
  localparam logic [1:0] CC_NEG     = 2'b11;

  // Datapath strobes driven by the sequencer (pc_in handled separately)
  typedef struct packed {
    logic gra;
    logic r_out;
    logic pc_out;
    logic y_in;
    logic c_out;
    logic alu_add;
    logic z_in;
    logic zlow_out;
  } strobe_t;

  // Moore decode of the strobes asserted in each state
  function automatic strobe_t strobes_for(state_e s);
    strobe_t st;
    st = '0;
    case (s)
      ST_T3: begin
        st.gra   = 1'b1;
        st.r_out = 1'b1;
      end
      ST_T4: begin
        st.pc_out = 1'b1;
        st.y_in   = 1'b1;
      end
      ST_T5: begin
        st.c_out   = 1'b1;
        st.alu_add = 1'b1;
        st.z_in    = 1'b1;
      end
      ST_T6: begin
        st.zlow_out = 1'b1;
      end
      default: st = '0;
    endcase
    return st;
  endfunction

endpackage

// File: rtl/branch_sequencer.sv
// Branch execute sequencer. Steps the datapath through T3..T6 for a branch
// instruction: reads Ra and latches the evaluator result into CON (T3),
// forms PC + C (T4/T5), and loads PC from Z only when CON is set (T6).
//
// Ports:
//   clk, clr_n        clock (rising edge) and async active-low reset
//   start             one-cycle request: IR holds a branch instruction
//   stall             freeze the sequence in its current state
//   ir                instruction register contents
//   cond_true         evaluator condition result, valid during T3
//   gra..zlow_out     datapath control strobes
//   pc_in             load PC in T6 when the branch is taken
//   con_q             latched CON flip-flop
//   busy, done        sequencer active / final execute cycle
//   taken_cnt         wrapping count of taken branches
//
// All outputs are registered: strobes are decoded from the next state so they
// line up with the state register in the same cycle.
module branch_sequencer
  import branch_sequencer_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             start,
  input  logic             stall,
  input  logic [31:0]      ir,
  input  logic             cond_true,
  output logic             gra,
  output logic             r_out,
  output logic             pc_out,
  output logic             y_in,
  output logic             c_out,
  output logic             alu_add,
  output logic             z_in,
  output logic             zlow_out,
  output logic             pc_in,
  output logic             con_q,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] taken_cnt
);

  state_e            r_state;
  state_e            w_next_state;
  logic              w_capture_ir;
  logic              w_sample_con;
  logic              w_count;

  logic [IR_W-1:0]   r_ir_q;
  logic              r_con_q;
  logic [CNT_W-1:0]  r_taken_cnt;
  strobe_t           r_strobes;
  logic              r_pc_in;
  logic              r_busy;
  logic              r_done;

  // State register
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and per-cycle control; stall leaves everything as is
  always_comb begin
    w_next_state = r_state;
    w_capture_ir = 1'b0;
    w_sample_con = 1'b0;
    w_count      = 1'b0;
    if (!stall) begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            w_next_state = ST_T3;
            w_capture_ir = 1'b1;
          end
        end
        ST_T3: begin
          w_next_state = ST_T4;
          w_sample_con = 1'b1;
        end
        ST_T4: w_next_state = ST_T5;
        ST_T5: w_next_state = ST_T6;
        ST_T6: begin
          // Count on the edge leaving T6 so a stalled T6 counts only once
          w_count = r_con_q;
          if (start) begin
            w_next_state = ST_T3;
            w_capture_ir = 1'b1;
          end else begin
            w_next_state = ST_IDLE;
          end
        end
        default: w_next_state = ST_IDLE;
      endcase
    end
  end

  // Datapath state, counter and registered outputs
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_ir_q      <= '0;
      r_con_q     <= 1'b0;
      r_taken_cnt <= '0;
      r_strobes   <= '0;
      r_pc_in     <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      if (w_capture_ir) begin
        r_ir_q <= ir;
      end
      if (w_sample_con) begin
        r_con_q <= cond_true;
      end
      if (w_count) begin
        r_taken_cnt <= r_taken_cnt + CNT_W'(1);
      end
      r_strobes <= strobes_for(w_next_state);
      // CON is already final by the time T6 is entered (latched leaving T3)
      r_pc_in   <= (w_next_state == ST_T6) && r_con_q;
      r_busy    <= (w_next_state != ST_IDLE);
      r_done    <= (w_next_state == ST_T6);
    end
  end

  // Main control must only hand over branch instructions
  a_branch_ir : assert property (@(posedge clk) disable iff (!clr_n)
    (r_state != ST_IDLE) |-> (!$isunknown(r_ir_q) &&
                               (r_ir_q[OPCODE_LSB +: OPCODE_W] == BR_OPCODE)));

  assign gra       = r_strobes.gra;
  assign r_out     = r_strobes.r_out;
  assign pc_out    = r_strobes.pc_out;
  assign y_in      = r_strobes.y_in;
  assign c_out     = r_strobes.c_out;
  assign alu_add   = r_strobes.alu_add;
  assign z_in      = r_strobes.z_in;
  assign zlow_out  = r_strobes.zlow_out;
  assign pc_in     = r_pc_in;
  assign con_q     = r_con_q;
  assign busy      = r_busy;
  assign done      = r_done;
  assign taken_cnt = r_taken_cnt;

endmodule

// File: tb/tb_branch_sequencer.sv
// Bench for branch_sequencer (4-bit counter instance so the wrap is reachable).
module tb_branch_sequencer;
  import branch_sequencer_pkg::*;

  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          clr_n;
  logic          start;
  logic          stall;
  logic [31:0]   ir;
  logic          cond_true;
  logic          gra, r_out, pc_out, y_in, c_out, alu_add, z_in, zlow_out;
  logic          pc_in, con_q, busy, done;
  logic [CW-1:0] taken_cnt;

  always #5 clk = ~clk;

  branch_sequencer #(.CNT_W(CW)) dut (
    .clk       (clk),
    .clr_n     (clr_n),
    .start     (start),
    .stall     (stall),
    .ir        (ir),
    .cond_true (cond_true),
    .gra       (gra),
    .r_out     (r_out),
    .pc_out    (pc_out),
    .y_in      (y_in),
    .c_out     (c_out),
    .alu_add   (alu_add),
    .z_in      (z_in),
    .zlow_out  (zlow_out),
    .pc_in     (pc_in),
    .con_q     (con_q),
    .busy      (busy),
    .done      (done),
    .taken_cnt (taken_cnt)
  );

  // brzr R2, 20 and brmi R2, 20
  localparam logic [31:0] IR_BRZR = {BR_OPCODE, 4'd2, 2'b00, CC_ZERO, 19'd20};
  localparam logic [31:0] IR_BRMI = {BR_OPCODE, 4'd2, 2'b00, CC_NEG,  19'd20};

  // {8 strobes, pc_in, busy, done, con_q, taken_cnt}
  typedef logic [12+CW-1:0] obs_t;

  typedef struct {
    logic          start;
    logic          stall;
    logic          cond;
    logic [31:0]   ir;
    int            ph;     // 0 = idle, 3..6 = T3..T6 after the edge
    logic          pc;
    logic          con;
    logic [CW-1:0] cnt;
  } vec_t;

  vec_t vecs[$];
  obs_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic obs_t expect_of(int ph, logic pc, logic con, logic [CW-1:0] cnt);
    logic [7:0] s;
    case (ph)
      3:       s = 8'b1100_0000;
      4:       s = 8'b0011_0000;
      5:       s = 8'b0000_1110;
      6:       s = 8'b0000_0001;
      default: s = 8'b0000_0000;
    endcase
    return {s, pc, (ph != 0), (ph == 6), con, cnt};
  endfunction

  function automatic obs_t observe();
    return {gra, r_out, pc_out, y_in, c_out, alu_add, z_in, zlow_out,
            pc_in, busy, done, con_q, taken_cnt};
  endfunction

  task automatic check(input string tag);
    obs_t e;
    obs_t a;
    a = observe();
    n_vec++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL %s: scoreboard empty, got %h", tag, a);
    end else begin
      e = exp_q.pop_front();
      if (a !== e) begin
        n_bad++;
        $display("FAIL %s: got %h want %h (strb,pc_in,busy,done,con,cnt)", tag, a, e);
      end
    end
  endtask

  task automatic apply(input vec_t v, input string tag);
    start     = v.start;
    stall     = v.stall;
    cond_true = v.cond;
    ir        = v.ir;
    exp_q.push_back(expect_of(v.ph, v.pc, v.con, v.cnt));
    @(posedge clk);
    #1;
    check(tag);
  endtask

  task automatic add(input logic s, input logic st, input logic c, input logic [31:0] i,
                     input int ph, input logic pc, input logic con, input logic [CW-1:0] cnt);
    vec_t v;
    v.start = s; v.stall = st; v.cond = c; v.ir = i;
    v.ph = ph; v.pc = pc; v.con = con; v.cnt = cnt;
    vecs.push_back(v);
  endtask

  task automatic run_vecs(input string name);
    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i], $sformatf("%s[%0d]", name, i));
    end
    vecs.delete();
  endtask

  task automatic do_reset();
    clr_n = 1'b0;
    @(posedge clk);
    #1;
    clr_n = 1'b1;
  endtask

  initial begin
    clr_n     = 1'b0;
    start     = 1'b0;
    stall     = 1'b0;
    cond_true = 1'b0;
    ir        = IR_BRZR;

    // Reset state
    #12;
    exp_q.push_back(expect_of(0, 1'b0, 1'b0, '0));
    check("reset_state");
    @(posedge clk);
    #1;
    clr_n = 1'b1;

    // Reset mid-T5 on a taken branch: abort at once, no pc_in afterwards
    add(1, 0, 0, IR_BRZR, 3, 0, 0, 0);
    add(0, 0, 1, IR_BRZR, 4, 0, 1, 0);
    add(0, 0, 0, IR_BRZR, 5, 0, 1, 0);
    run_vecs("pre_rst");
    clr_n = 1'b0;
    #1;
    exp_q.push_back(expect_of(0, 1'b0, 1'b0, '0));
    check("rst_mid_t5_async");
    @(posedge clk);
    #1;
    exp_q.push_back(expect_of(0, 1'b0, 1'b0, '0));
    check("rst_mid_t5_held");
    clr_n = 1'b1;
    add(0, 0, 0, IR_BRZR, 0, 0, 0, 0);
    add(0, 0, 0, IR_BRZR, 0, 0, 0, 0);
    run_vecs("post_rst");

    // Branch-if-zero, condition true
    add(1, 0, 0, IR_BRZR, 3, 0, 0, 0);
    add(0, 0, 1, IR_BRZR, 4, 0, 1, 0);
    add(0, 0, 0, IR_BRZR, 5, 0, 1, 0);
    add(0, 0, 0, IR_BRZR, 6, 1, 1, 0);
    add(0, 0, 0, IR_BRZR, 0, 0, 1, 1);
    run_vecs("brzr_taken");

    // Branch-if-negative on +5, condition false; cond_true ignored outside T3
    add(1, 0, 1, IR_BRMI, 3, 0, 1, 1);
    add(0, 0, 0, IR_BRMI, 4, 0, 0, 1);
    add(0, 0, 1, IR_BRMI, 5, 0, 0, 1);
    add(0, 0, 1, IR_BRMI, 6, 0, 0, 1);
    add(0, 0, 1, IR_BRMI, 0, 0, 0, 1);
    run_vecs("brmi_not_taken");

    // Back-to-back branches; start while busy outside T6 ignored
    add(1, 0, 0, IR_BRZR, 3, 0, 0, 1);
    add(0, 0, 1, IR_BRZR, 4, 0, 1, 1);
    add(0, 0, 0, IR_BRZR, 5, 0, 1, 1);
    add(0, 0, 0, IR_BRZR, 6, 1, 1, 1);
    add(1, 0, 0, IR_BRMI, 3, 0, 1, 2);
    add(1, 0, 0, IR_BRMI, 4, 0, 0, 2);
    add(1, 0, 1, IR_BRMI, 5, 0, 0, 2);
    add(0, 0, 1, IR_BRMI, 6, 0, 0, 2);
    add(0, 0, 0, IR_BRMI, 0, 0, 0, 2);
    run_vecs("back_to_back");

    // Stall: in IDLE, 3 cycles in T4, 2 cycles in T6 (start ignored there)
    add(1, 1, 1, IR_BRZR, 0, 0, 0, 2);
    add(1, 0, 0, IR_BRZR, 3, 0, 0, 2);
    add(0, 0, 1, IR_BRZR, 4, 0, 1, 2);
    add(0, 1, 0, IR_BRZR, 4, 0, 1, 2);
    add(0, 1, 0, IR_BRZR, 4, 0, 1, 2);
    add(0, 1, 0, IR_BRZR, 4, 0, 1, 2);
    add(0, 0, 0, IR_BRZR, 5, 0, 1, 2);
    add(0, 0, 0, IR_BRZR, 6, 1, 1, 2);
    add(1, 1, 0, IR_BRZR, 6, 1, 1, 2);
    add(0, 1, 0, IR_BRZR, 6, 1, 1, 2);
    add(0, 0, 0, IR_BRZR, 0, 0, 1, 3);
    run_vecs("stall");

    // Counter wrap: 16 taken branches from zero
    do_reset();
    for (int k = 1; k <= 16; k++) begin
      add(1, 0, 0, IR_BRZR, 3, 0, (k == 1) ? 1'b0 : 1'b1, CW'(k - 1));
      add(0, 0, 1, IR_BRZR, 4, 0, 1, CW'(k - 1));
      add(0, 0, 0, IR_BRZR, 5, 0, 1, CW'(k - 1));
      add(0, 0, 0, IR_BRZR, 6, 1, 1, CW'(k - 1));
      add(0, 0, 0, IR_BRZR, 0, 0, 1, CW'(k));
    end
    run_vecs("wrap");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
